// File: rtl/vga_pkg.sv
// Shared VGA display-path definitions: 640x480 timing, pixel width,
// coordinate type and motion direction encoding.
package vga_pkg;

   // 640x480 @ 60 Hz timing
   localparam int H_RES   = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;
   localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;   // 800

   localparam int V_RES   = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;
   localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;   // 525

   // 4:4:4 RGB pixel
   localparam int DW = 12;

   // Screen coordinate pair
   localparam int COORD_W = 10;
   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } coord_t;

   // Motion direction: POS = towards larger coordinates (right/down)
   localparam logic DIR_POS = 1'b0;
   localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing sprite: position, direction and the
// clamp/reflect step applied on each motion update.
module bounce_axis
   import vga_pkg::*;
#(
   parameter int   CW       = 10,
   parameter int   BOUND    = 512,     // largest legal position
   parameter int   INIT_POS = 0,
   parameter logic INIT_DIR = DIR_POS
) (
   input  logic          clk,
   input  logic          rst,          // asynchronous, active low
   input  logic          upd,          // one-cycle motion update strobe
   input  logic [3:0]    step,
   output logic [CW-1:0] pos,
   output logic          dir,
   output logic          hit           // reflection happening this update
);

   localparam logic [CW:0] BOUND_W = (CW+1)'(BOUND);

   logic [CW:0] step_w;
   logic [CW:0] pos_w;
   logic [CW:0] nx_inc;
   logic        moving;
   logic        hit_pos;
   logic        hit_neg;

   // One extra bit so the forward sum can never wrap past the bound
   assign step_w  = {{(CW-3){1'b0}}, step};
   assign pos_w   = {1'b0, pos};
   assign nx_inc  = pos_w + step_w;
   // A zero step must never reflect, even when parked on a bound
   assign moving  = upd && (step != 4'd0);
   assign hit_pos = (dir == DIR_POS) && (nx_inc >= BOUND_W);
   assign hit_neg = (dir == DIR_NEG) && (pos_w < step_w);
   assign hit     = moving && (hit_pos || hit_neg);

   // Advance, or clamp to the edge and reverse when the step would cross it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pos <= CW'(INIT_POS);
         dir <= INIT_DIR;
      end else if (moving) begin
         if (dir == DIR_POS) begin
            if (hit_pos) begin
               pos <= BOUND_W[CW-1:0];
               dir <= DIR_NEG;
            end else begin
               pos <= nx_inc[CW-1:0];
            end
         end else begin
            if (hit_neg) begin
               pos <= '0;
               dir <= DIR_POS;
            end else begin
               pos <= pos - step_w[CW-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/sprite_bounce_engine.sv
// Bouncing-sprite engine: frame divider, two bounce axes, reflection
// status, and a 2-stage pixel pipeline feeding the sprite ROM.
module sprite_bounce_engine
   import vga_pkg::DIR_POS, vga_pkg::DIR_NEG;
#(
   parameter int H_RES     = vga_pkg::H_RES,
   parameter int V_RES     = vga_pkg::V_RES,
   parameter int SPR_W     = 128,
   parameter int SPR_H     = 128,
   parameter int CW        = 10,
   parameter int DW        = vga_pkg::DW,
   parameter int FRAME_DIV = 1,
   parameter int X0        = 430,
   parameter int Y0        = 50,
   parameter logic [DW-1:0] BG = '0,
   localparam int XW = $clog2(SPR_W),
   localparam int YW = $clog2(SPR_H),
   localparam int AW = XW + YW
) (
   input  logic          clk,
   input  logic          rst,          // asynchronous, active low
   input  logic          frame_tick,
   input  logic          valid,
   input  logic [CW-1:0] h_cnt,
   input  logic [CW-1:0] v_cnt,
   input  logic          enable,
   input  logic [3:0]    step,
   input  logic [DW-1:0] rom_data,
   output logic [AW-1:0] rom_addr,
   output logic [DW-1:0] rgb,
   output logic          rgb_valid,
   output logic [CW-1:0] spr_x,
   output logic [CW-1:0] spr_y,
   output logic          dir_x,
   output logic          dir_y,
   output logic          edge_hit,
   output logic          corner_hit,
   output logic [15:0]   bounce_cnt
);

   localparam logic [CW:0] X_SPAN = (CW+1)'(SPR_W - 1);
   localparam logic [CW:0] Y_SPAN = (CW+1)'(SPR_H - 1);

   logic [7:0]    div_cnt;
   logic          fire;
   logic          hit_x;
   logic          hit_y;
   logic [CW:0]   x_lo, x_hi, y_lo, y_hi, h_w, v_w;
   logic          in_spr;
   logic          in_spr_d1;
   logic          valid_d1;
   logic [XW-1:0] off_x;
   logic [YW-1:0] off_y;

   // Update fires on the tick that completes FRAME_DIV enabled frames
   assign fire = frame_tick && enable && (div_cnt == 8'(FRAME_DIV - 1));

   // Count enabled frames; a disabled tick leaves the count untouched
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (frame_tick && enable) begin
         div_cnt <= fire ? 8'd0 : div_cnt + 8'd1;
      end
   end

   bounce_axis #(
      .CW(CW), .BOUND(H_RES - SPR_W), .INIT_POS(X0), .INIT_DIR(DIR_POS)
   ) u_axis_x (
      .clk(clk), .rst(rst), .upd(fire), .step(step),
      .pos(spr_x), .dir(dir_x), .hit(hit_x)
   );

   bounce_axis #(
      .CW(CW), .BOUND(V_RES - SPR_H), .INIT_POS(Y0), .INIT_DIR(DIR_NEG)
   ) u_axis_y (
      .clk(clk), .rst(rst), .upd(fire), .step(step),
      .pos(spr_y), .dir(dir_y), .hit(hit_y)
   );

   // Reflection pulses and running count, one cycle after the update
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_hit   <= 1'b0;
         corner_hit <= 1'b0;
         bounce_cnt <= '0;
      end else begin
         edge_hit   <= hit_x || hit_y;
         corner_hit <= hit_x && hit_y;
         bounce_cnt <= bounce_cnt + 16'(hit_x) + 16'(hit_y);
      end
   end

   // Stage 0: sprite window test, widened so the far edge cannot wrap
   assign h_w    = {1'b0, h_cnt};
   assign v_w    = {1'b0, v_cnt};
   assign x_lo   = {1'b0, spr_x};
   assign y_lo   = {1'b0, spr_y};
   assign x_hi   = x_lo + X_SPAN;
   assign y_hi   = y_lo + Y_SPAN;
   assign in_spr = valid && (h_w >= x_lo) && (h_w <= x_hi)
                         && (v_w >= y_lo) && (v_w <= y_hi);
   assign off_x  = XW'(h_cnt - spr_x);
   assign off_y  = YW'(v_cnt - spr_y);

   // Stage 1: ROM address (held outside the sprite) and delayed flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rom_addr  <= '0;
         in_spr_d1 <= 1'b0;
         valid_d1  <= 1'b0;
      end else begin
         if (in_spr) begin
            rom_addr <= {off_y, off_x};
         end
         in_spr_d1 <= in_spr;
         valid_d1  <= valid;
      end
   end

   // Stage 2: select sprite pixel, background fill or blanking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rgb       <= '0;
         rgb_valid <= 1'b0;
      end else begin
         rgb       <= valid_d1 ? (in_spr_d1 ? rom_data : BG) : '0;
         rgb_valid <= valid_d1;
      end
   end

endmodule

// File: tb/tb_sprite_bounce_engine.sv
// Directed bench for sprite_bounce_engine. Five instances with different
// start positions / dividers share the stimulus; each has its own tick.
//   0: defaults            1: X0=510,Y0=50        2: X0=512,Y0=2
//   3: FRAME_DIV=3         4: X0=100,Y0=40,BG=0F0 (pixel path, never ticked)
module tb_sprite_bounce_engine;

   logic        clk;
   logic        rst_n;
   logic [4:0]  tick;
   logic        valid;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        enable;
   logic [3:0]  step;
   logic [11:0] rom_data;

   logic [4:0][13:0] ra;
   logic [4:0][11:0] rgb_o;
   logic [4:0]       rv;
   logic [4:0][9:0]  sx;
   logic [4:0][9:0]  sy;
   logic [4:0]       dxo;
   logic [4:0]       dyo;
   logic [4:0]       eh;
   logic [4:0]       ch;
   logic [4:0][15:0] bc;

   int n_checks;
   int n_fail;

   sprite_bounce_engine u_a (
      .clk(clk), .rst(rst_n), .frame_tick(tick[0]), .valid(valid),
      .h_cnt(h_cnt), .v_cnt(v_cnt), .enable(enable), .step(step),
      .rom_data(rom_data), .rom_addr(ra[0]), .rgb(rgb_o[0]), .rgb_valid(rv[0]),
      .spr_x(sx[0]), .spr_y(sy[0]), .dir_x(dxo[0]), .dir_y(dyo[0]),
      .edge_hit(eh[0]), .corner_hit(ch[0]), .bounce_cnt(bc[0]));

   sprite_bounce_engine #(.X0(510), .Y0(50)) u_b (
      .clk(clk), .rst(rst_n), .frame_tick(tick[1]), .valid(valid),
      .h_cnt(h_cnt), .v_cnt(v_cnt), .enable(enable), .step(step),
      .rom_data(rom_data), .rom_addr(ra[1]), .rgb(rgb_o[1]), .rgb_valid(rv[1]),
      .spr_x(sx[1]), .spr_y(sy[1]), .dir_x(dxo[1]), .dir_y(dyo[1]),
      .edge_hit(eh[1]), .corner_hit(ch[1]), .bounce_cnt(bc[1]));

   sprite_bounce_engine #(.X0(512), .Y0(2)) u_c (
      .clk(clk), .rst(rst_n), .frame_tick(tick[2]), .valid(valid),
      .h_cnt(h_cnt), .v_cnt(v_cnt), .enable(enable), .step(step),
      .rom_data(rom_data), .rom_addr(ra[2]), .rgb(rgb_o[2]), .rgb_valid(rv[2]),
      .spr_x(sx[2]), .spr_y(sy[2]), .dir_x(dxo[2]), .dir_y(dyo[2]),
      .edge_hit(eh[2]), .corner_hit(ch[2]), .bounce_cnt(bc[2]));

   sprite_bounce_engine #(.FRAME_DIV(3)) u_d (
      .clk(clk), .rst(rst_n), .frame_tick(tick[3]), .valid(valid),
      .h_cnt(h_cnt), .v_cnt(v_cnt), .enable(enable), .step(step),
      .rom_data(rom_data), .rom_addr(ra[3]), .rgb(rgb_o[3]), .rgb_valid(rv[3]),
      .spr_x(sx[3]), .spr_y(sy[3]), .dir_x(dxo[3]), .dir_y(dyo[3]),
      .edge_hit(eh[3]), .corner_hit(ch[3]), .bounce_cnt(bc[3]));

   sprite_bounce_engine #(.X0(100), .Y0(40), .BG(12'h0F0)) u_p (
      .clk(clk), .rst(rst_n), .frame_tick(tick[4]), .valid(valid),
      .h_cnt(h_cnt), .v_cnt(v_cnt), .enable(enable), .step(step),
      .rom_data(rom_data), .rom_addr(ra[4]), .rgb(rgb_o[4]), .rgb_valid(rv[4]),
      .spr_x(sx[4]), .spr_y(sy[4]), .dir_x(dxo[4]), .dir_y(dyo[4]),
      .edge_hit(eh[4]), .corner_hit(ch[4]), .bounce_cnt(bc[4]));

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [4:0] m);
      tick = m;
      @(posedge clk);
      #1;
      tick = '0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      tick     = '0;
      valid    = 1'b0;
      h_cnt    = '0;
      v_cnt    = '0;
      enable   = 1'b0;
      step     = '0;
      rom_data = '0;

      // Reset state
      #12;
      check("rst_x",      32'(sx[0]), 430);
      check("rst_y",      32'(sy[0]), 50);
      check("rst_dirx",   32'(dxo[0]), 0);
      check("rst_diry",   32'(dyo[0]), 1);
      check("rst_edge",   32'(eh[0]), 0);
      check("rst_cnt",    32'(bc[0]), 0);
      check("rst_addr",   32'(ra[4]), 0);
      check("rst_rgbv",   32'(rv[4]), 0);
      rst_n = 1'b1;
      cyc();

      // Plain motion: right/up by 1
      enable = 1'b1;
      step   = 4'd1;
      pulse(5'b00001);
      check("mv_x",    32'(sx[0]), 431);
      check("mv_y",    32'(sy[0]), 49);
      check("mv_dirx", 32'(dxo[0]), 0);
      check("mv_diry", 32'(dyo[0]), 1);
      check("mv_edge", 32'(eh[0]), 0);

      // Right edge, landing exactly on the bound: 510+2 = 512 reflects
      step = 4'd2;
      pulse(5'b00010);
      check("re_x",      32'(sx[1]), 512);
      check("re_y",      32'(sy[1]), 48);
      check("re_dirx",   32'(dxo[1]), 1);
      check("re_edge",   32'(eh[1]), 1);
      check("re_corner", 32'(ch[1]), 0);
      check("re_cnt",    32'(bc[1]), 1);
      cyc();
      check("re_edge_end", 32'(eh[1]), 0);
      check("re_cnt_hold", 32'(bc[1]), 1);
      step = 4'd3;
      pulse(5'b00010);
      check("re_back_x", 32'(sx[1]), 509);
      check("re_back_y", 32'(sy[1]), 45);
      check("re_back_e", 32'(eh[1]), 0);

      // Zero step while parked on the right bound moving right: no reflection
      step = 4'd0;
      pulse(5'b00100);
      check("z_x",    32'(sx[2]), 512);
      check("z_dirx", 32'(dxo[2]), 0);
      check("z_edge", 32'(eh[2]), 0);
      check("z_cnt",  32'(bc[2]), 0);

      // Corner: x clamps at 512, y (2 < 3) clamps at 0, both flip
      step = 4'd3;
      pulse(5'b00100);
      check("cn_x",      32'(sx[2]), 512);
      check("cn_y",      32'(sy[2]), 0);
      check("cn_dirx",   32'(dxo[2]), 1);
      check("cn_diry",   32'(dyo[2]), 0);
      check("cn_edge",   32'(eh[2]), 1);
      check("cn_corner", 32'(ch[2]), 1);
      check("cn_cnt",    32'(bc[2]), 2);
      cyc();
      check("cn_corner_end", 32'(ch[2]), 0);
      step = 4'd4;
      pulse(5'b00100);
      check("cn_after_x", 32'(sx[2]), 508);
      check("cn_after_y", 32'(sy[2]), 4);
      check("cn_after_c", 32'(bc[2]), 2);

      // Divider of 3 with ticks 2-3 disabled: the update lands on tick 5
      step   = 4'd1;
      enable = 1'b1;
      pulse(5'b01000);
      check("dv_t1_x", 32'(sx[3]), 430);
      enable = 1'b0;
      pulse(5'b01001);
      check("dv_t2_x",  32'(sx[3]), 430);
      check("dv_frz_a", 32'(sx[0]), 431);
      pulse(5'b01000);
      check("dv_t3_x", 32'(sx[3]), 430);
      enable = 1'b1;
      pulse(5'b01000);
      check("dv_t4_x", 32'(sx[3]), 430);
      check("dv_t4_y", 32'(sy[3]), 50);
      pulse(5'b01000);
      check("dv_t5_x", 32'(sx[3]), 431);
      check("dv_t5_y", 32'(sy[3]), 49);
      pulse(5'b01000);
      check("dv_t6_x", 32'(sx[3]), 431);

      // Pixel pipeline on the sprite at (100,40)
      valid = 1'b1;
      h_cnt = 10'd105;
      v_cnt = 10'd41;
      cyc();
      check("px_addr_133", 32'(ra[4]), 133);
      h_cnt = 10'd100; v_cnt = 10'd40; rom_data = 12'h111;
      cyc();
      check("px_addr_0",  32'(ra[4]), 0);
      check("px_rgb_111", 32'(rgb_o[4]), 'h111);
      check("px_rgbv",    32'(rv[4]), 1);
      h_cnt = 10'd101; rom_data = 12'hA5C;
      cyc();
      check("px_addr_1",  32'(ra[4]), 1);
      check("px_rgb_a5c", 32'(rgb_o[4]), 'hA5C);
      h_cnt = 10'd228; rom_data = 12'h3C7;
      cyc();
      check("px_addr_hold", 32'(ra[4]), 1);
      check("px_rgb_3c7",   32'(rgb_o[4]), 'h3C7);
      h_cnt = 10'd227; rom_data = 12'hBBB;
      cyc();
      check("px_addr_127", 32'(ra[4]), 127);
      check("px_rgb_bg",   32'(rgb_o[4]), 'h0F0);
      check("px_rgbv_bg",  32'(rv[4]), 1);
      valid = 1'b0; h_cnt = 10'd100; v_cnt = 10'd40; rom_data = 12'h777;
      cyc();
      check("px_addr_blank", 32'(ra[4]), 127);
      check("px_rgb_edge",   32'(rgb_o[4]), 'h777);
      rom_data = 12'h999;
      cyc();
      check("px_rgb_blank",  32'(rgb_o[4]), 0);
      check("px_rgbv_blank", 32'(rv[4]), 0);

      // Reset asserted in the middle of an update cycle
      enable = 1'b1;
      step   = 4'd1;
      tick   = 5'b00111;
      #3;
      rst_n  = 1'b0;
      #1;
      check("ar_x",    32'(sx[0]), 430);
      check("ar_y",    32'(sy[0]), 50);
      check("ar_b_x",  32'(sx[1]), 510);
      check("ar_b_dx", 32'(dxo[1]), 0);
      check("ar_b_c",  32'(bc[1]), 0);
      check("ar_c_c",  32'(bc[2]), 0);
      check("ar_addr", 32'(ra[4]), 0);
      tick = '0;
      cyc();
      check("ar_hold_x", 32'(sx[0]), 430);
      #4;
      rst_n = 1'b1;
      cyc();
      pulse(5'b00001);
      check("ar_first_x", 32'(sx[0]), 431);
      check("ar_first_y", 32'(sy[0]), 49);
      check("ar_first_e", 32'(eh[0]), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
